// File: rtl/systolic_feeder_sparse.sv
// Block feeder for the sparse systolic array: weight-row burst, skewed activation stream, zero-block skip.
// Row r of a_in_flat / b_in_flat occupies bits [r*DATA_W +: DATA_W].
module systolic_feeder_sparse #(
    parameter int unsigned N_ROWS = 16,
    parameter int unsigned N_COLS = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 9,
    parameter int unsigned SKEW   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_W-1:0]          cmd_wgt_addr,
    input  logic [ADDR_W-1:0]          cmd_act_addr,
    input  logic [LEN_W-1:0]           cmd_len,
    input  logic                       cmd_zero,
    output logic                       wgt_rd_en,
    output logic [ADDR_W-1:0]          wgt_rd_addr,
    input  logic [N_COLS*DATA_W-1:0]   wgt_rd_data,
    output logic                       act_rd_en,
    output logic [ADDR_W-1:0]          act_rd_addr,
    input  logic [N_ROWS*DATA_W-1:0]   act_rd_data,
    output logic                       load_weight,
    output logic [N_COLS*DATA_W-1:0]   b_in_flat,
    output logic                       block_valid,
    output logic [N_ROWS*DATA_W-1:0]   a_in_flat,
    output logic                       done,
    output logic [15:0]                skip_cnt
);

    localparam int unsigned NR_W      = $clog2(N_ROWS) + 1;
    localparam int unsigned CNT_W     = (LEN_W > NR_W) ? LEN_W : NR_W;
    localparam int unsigned DRAIN_LEN = (SKEW != 0) ? N_ROWS : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_SKIP   = 3'd4;

    logic [2:0]          r_state,       w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,         w_cnt_nxt;
    logic [ADDR_W-1:0]   r_act_base,    w_act_base_nxt;
    logic [LEN_W-1:0]    r_len,         w_len_nxt;
    logic                r_cmd_ready,   w_cmd_ready_nxt;
    logic                r_wgt_rd_en,   w_wgt_rd_en_nxt;
    logic [ADDR_W-1:0]   r_wgt_rd_addr, w_wgt_rd_addr_nxt;
    logic                r_act_rd_en,   w_act_rd_en_nxt;
    logic [ADDR_W-1:0]   r_act_rd_addr, w_act_rd_addr_nxt;
    logic                r_load_weight, w_load_weight_nxt;
    logic                r_block_valid, w_block_valid_nxt;
    logic                r_done,        w_done_nxt;
    logic [15:0]         r_skip_cnt,    w_skip_cnt_nxt;
    logic                r_act_vld;
    logic [N_ROWS*DATA_W-1:0] w_a_rows;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_act_base_nxt    = r_act_base;
        w_len_nxt         = r_len;
        w_cmd_ready_nxt   = 1'b0;
        w_wgt_rd_en_nxt   = 1'b0;
        w_wgt_rd_addr_nxt = r_wgt_rd_addr;
        w_act_rd_en_nxt   = 1'b0;
        w_act_rd_addr_nxt = r_act_rd_addr;
        w_load_weight_nxt = 1'b0;
        w_block_valid_nxt = 1'b0;
        w_done_nxt        = 1'b0;
        w_skip_cnt_nxt    = r_skip_cnt;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_act_base_nxt  = cmd_act_addr;
                    w_len_nxt       = cmd_len;
                    w_cnt_nxt       = '0;
                    if (cmd_zero || (cmd_len == '0)) begin
                        w_state_nxt = S_SKIP;
                        w_done_nxt  = 1'b1;
                        if (r_skip_cnt != 16'hFFFF)
                            w_skip_cnt_nxt = r_skip_cnt + 16'd1;
                    end else begin
                        w_state_nxt       = S_LOAD_W;
                        w_wgt_rd_en_nxt   = 1'b1;
                        w_wgt_rd_addr_nxt = cmd_wgt_addr;
                    end
                end
            end
            S_LOAD_W: begin
                // Read data lags the strobe by one cycle, so load_weight trails wgt_rd_en.
                w_load_weight_nxt = 1'b1;
                if (r_cnt == CNT_W'(N_ROWS - 1)) begin
                    w_state_nxt       = S_STREAM;
                    w_cnt_nxt         = '0;
                    w_act_rd_en_nxt   = 1'b1;
                    w_act_rd_addr_nxt = r_act_base;
                end else begin
                    w_cnt_nxt         = r_cnt + CNT_W'(1);
                    w_wgt_rd_en_nxt   = 1'b1;
                    w_wgt_rd_addr_nxt = r_wgt_rd_addr + ADDR_W'(1);
                end
            end
            S_STREAM: begin
                w_block_valid_nxt = 1'b1;
                if (r_cnt == CNT_W'(r_len - LEN_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt         = r_cnt + CNT_W'(1);
                    w_act_rd_en_nxt   = 1'b1;
                    w_act_rd_addr_nxt = r_act_rd_addr + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == CNT_W'(DRAIN_LEN - 1)) begin
                    w_state_nxt     = S_IDLE;
                    w_done_nxt      = 1'b1;
                    w_cmd_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt         = r_cnt + CNT_W'(1);
                    w_block_valid_nxt = 1'b1;
                end
            end
            S_SKIP: begin
                w_state_nxt     = S_IDLE;
                w_cmd_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_cmd_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_act_base    <= '0;
            r_len         <= '0;
            r_cmd_ready   <= 1'b1;
            r_wgt_rd_en   <= 1'b0;
            r_wgt_rd_addr <= '0;
            r_act_rd_en   <= 1'b0;
            r_act_rd_addr <= '0;
            r_load_weight <= 1'b0;
            r_block_valid <= 1'b0;
            r_done        <= 1'b0;
            r_skip_cnt    <= '0;
            r_act_vld     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_act_base    <= w_act_base_nxt;
            r_len         <= w_len_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_wgt_rd_en   <= w_wgt_rd_en_nxt;
            r_wgt_rd_addr <= w_wgt_rd_addr_nxt;
            r_act_rd_en   <= w_act_rd_en_nxt;
            r_act_rd_addr <= w_act_rd_addr_nxt;
            r_load_weight <= w_load_weight_nxt;
            r_block_valid <= w_block_valid_nxt;
            r_done        <= w_done_nxt;
            r_skip_cnt    <= w_skip_cnt_nxt;
            r_act_vld     <= r_act_rd_en;
        end
    end

    // Per-row skew: row r carries its slice of each beat through r delay stages, tagged by a valid bit.
    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        localparam int unsigned DLY = (SKEW != 0) ? r : 0;
        if (DLY == 0) begin : g_direct
            assign w_a_rows[r*DATA_W +: DATA_W] =
                r_act_vld ? act_rd_data[r*DATA_W +: DATA_W] : '0;
        end else begin : g_skew
            logic [DATA_W-1:0] r_d [DLY];
            logic [DLY-1:0]    r_v;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= '0;
                    for (int k = 0; k < DLY; k++) r_d[k] <= '0;
                end else begin
                    r_d[0] <= act_rd_data[r*DATA_W +: DATA_W];
                    r_v[0] <= r_act_vld;
                    for (int k = 1; k < DLY; k++) begin
                        r_d[k] <= r_d[k-1];
                        r_v[k] <= r_v[k-1];
                    end
                end
            end
            assign w_a_rows[r*DATA_W +: DATA_W] = r_v[DLY-1] ? r_d[DLY-1] : '0;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign wgt_rd_en   = r_wgt_rd_en;
    assign wgt_rd_addr = r_wgt_rd_addr;
    assign act_rd_en   = r_act_rd_en;
    assign act_rd_addr = r_act_rd_addr;
    assign load_weight = r_load_weight;
    assign block_valid = r_block_valid;
    assign done        = r_done;
    assign skip_cnt    = r_skip_cnt;
    assign b_in_flat   = r_load_weight ? wgt_rd_data : '0;
    assign a_in_flat   = r_block_valid ? w_a_rows : '0;

endmodule

// File: tb/tb_systolic_feeder_sparse.sv
// Bench for systolic_feeder_sparse: buffer models, per-cycle output log, and a timeline model of each block.
module tb_systolic_feeder_sparse;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 9;
    localparam int LOG_N = 4096;

    typedef struct packed {
        logic          cmd_ready;
        logic          wgt_rd_en;
        logic [AW-1:0] wgt_rd_addr;
        logic          act_rd_en;
        logic [AW-1:0] act_rd_addr;
        logic          load_weight;
        logic [NC*DW-1:0] b_flat;
        logic          block_valid;
        logic [NR*DW-1:0] a_flat;
        logic          done;
        logic [15:0]   skip;
    } obs_t;

    typedef struct {
        logic [AW-1:0] wa;
        logic [AW-1:0] aa;
        logic [LW-1:0] len;
        logic          zero;
    } cmd_t;

    logic clk = 1'b0;
    logic rst;
    logic cmd_valid;
    logic cmd_ready;
    logic [AW-1:0] cmd_wgt_addr;
    logic [AW-1:0] cmd_act_addr;
    logic [LW-1:0] cmd_len;
    logic cmd_zero;
    logic wgt_rd_en;
    logic [AW-1:0] wgt_rd_addr;
    logic [NC*DW-1:0] wgt_rd_data = '0;
    logic act_rd_en;
    logic [AW-1:0] act_rd_addr;
    logic [NR*DW-1:0] act_rd_data = '0;
    logic load_weight;
    logic [NC*DW-1:0] b_in_flat;
    logic block_valid;
    logic [NR*DW-1:0] a_in_flat;
    logic done;
    logic [15:0] skip_cnt;

    logic [NC*DW-1:0] wmem [1<<AW];
    logic [NR*DW-1:0] amem [1<<AW];
    obs_t log_mem [LOG_N];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_skip = '0;

    systolic_feeder_sparse #(
        .N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .SKEW(1)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wgt_addr(cmd_wgt_addr), .cmd_act_addr(cmd_act_addr),
        .cmd_len(cmd_len), .cmd_zero(cmd_zero),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .load_weight(load_weight), .b_in_flat(b_in_flat),
        .block_valid(block_valid), .a_in_flat(a_in_flat),
        .done(done), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    // Buffers return data one cycle after the read strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wgt_rd_en) wgt_rd_data <= wmem[wgt_rd_addr];
        if (act_rd_en) act_rd_data <= amem[act_rd_addr];
    end

    function automatic obs_t cur_obs();
        obs_t o;
        o.cmd_ready = cmd_ready;      o.wgt_rd_en = wgt_rd_en;
        o.wgt_rd_addr = wgt_rd_addr;  o.act_rd_en = act_rd_en;
        o.act_rd_addr = act_rd_addr;  o.load_weight = load_weight;
        o.b_flat = b_in_flat;         o.block_valid = block_valid;
        o.a_flat = a_in_flat;         o.done = done;
        o.skip = skip_cnt;
        return o;
    endfunction

    always @(negedge clk) if (cyc < LOG_N) log_mem[cyc] = cur_obs();

    // Addresses are don't-care while their strobe is low.
    function automatic obs_t mask(obs_t o);
        obs_t m = o;
        if (m.wgt_rd_en !== 1'b1) m.wgt_rd_addr = '0;
        if (m.act_rd_en !== 1'b1) m.act_rd_addr = '0;
        return m;
    endfunction

    // Expected outputs k cycles after the cycle a command is accepted in, from the block timeline.
    function automatic obs_t model(cmd_t c, int k, logic [15:0] s0);
        obs_t e = '0;
        int len = int'(c.len);
        int d;
        logic [AW-1:0] ad;
        logic [NR*DW-1:0] beat;
        e.skip = s0;
        if (c.zero || len == 0) begin
            e.cmd_ready = (k != 1);
            e.done = (k == 1);
            if (k >= 1) e.skip = (s0 == 16'hFFFF) ? s0 : s0 + 16'd1;
            return e;
        end
        d = 2*NR + len + 1;
        e.cmd_ready = (k <= 0) || (k >= d);
        e.done = (k == d);
        if (k >= 1 && k <= NR) begin
            e.wgt_rd_en = 1'b1;
            e.wgt_rd_addr = c.wa + AW'(k - 1);
        end
        if (k >= 2 && k <= NR + 1) begin
            e.load_weight = 1'b1;
            ad = c.wa + AW'(k - 2);
            e.b_flat = wmem[ad];
        end
        if (k >= NR + 1 && k <= NR + len) begin
            e.act_rd_en = 1'b1;
            e.act_rd_addr = c.aa + AW'(k - NR - 1);
        end
        e.block_valid = (k >= NR + 2) && (k <= 2*NR + len);
        for (int r = 0; r < NR; r++) begin
            int j = k - NR - 2 - r;
            if (j >= 0 && j < len) begin
                ad = c.aa + AW'(j);
                beat = amem[ad];
                e.a_flat[r*DW +: DW] = beat[r*DW +: DW];
            end
        end
        return e;
    endfunction

    function automatic int blk_len(cmd_t c);
        return (c.zero || c.len == '0) ? 1 : 2*NR + int'(c.len) + 1;
    endfunction

    task automatic issue(input cmd_t c, output int t);
        @(negedge clk);
        cmd_wgt_addr = c.wa; cmd_act_addr = c.aa; cmd_len = c.len; cmd_zero = c.zero;
        cmd_valid = 1'b1;
        t = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        obs_t idle;
        cmd_t c = '{wa: '0, aa: '0, len: 9'd1, zero: 1'b0};
        idle = model(c, 0, 16'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (mask(cur_obs()) !== idle) begin
            n_err++; $display("FAIL reset_hold got %h exp %h", mask(cur_obs()), idle);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mask(cur_obs()) !== idle) begin
            n_err++; $display("FAIL reset_release got %h exp %h", mask(cur_obs()), idle);
        end
        exp_skip = '0;
    endtask

    task automatic test_spec_block();
        cmd_t c = '{wa: 10'd0, aa: 10'd8, len: 9'd3, zero: 1'b0};
        int t, d;
        int exp_r2 [5] = '{0, 0, 2, 12, 22};
        int exp_r0 [4] = '{0, 10, 20, 0};
        logic [NR*DW-1:0] a;
        for (int j = 0; j < 3; j++)
            for (int r = 0; r < NR; r++) amem[8+j][r*DW +: DW] = DW'(10*j + r);
        d = blk_len(c);
        issue(c, t);
        repeat (d + 2) @(negedge clk);
        for (int k = 0; k <= d + 1; k++) begin
            n_vec++;
            if (mask(log_mem[t+k]) !== mask(model(c, k, exp_skip))) begin
                n_err++;
                $display("FAIL spec_blk k=%0d got %h exp %h", k, mask(log_mem[t+k]), mask(model(c, k, exp_skip)));
            end
        end
        for (int i = 0; i < 5; i++) begin
            a = log_mem[t+6+i].a_flat;
            n_vec++;
            if (int'(a[2*DW +: DW]) !== exp_r2[i]) begin
                n_err++; $display("FAIL skew_row2 i=%0d got %0d exp %0d", i, a[2*DW +: DW], exp_r2[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            a = log_mem[t+6+i].a_flat;
            n_vec++;
            if (int'(a[0 +: DW]) !== exp_r0[i]) begin
                n_err++; $display("FAIL skew_row0 i=%0d got %0d exp %0d", i, a[0 +: DW], exp_r0[i]);
            end
        end
        n_vec++;
        if (log_mem[t+12].done !== 1'b1 || log_mem[t+11].block_valid !== 1'b1) begin
            n_err++; $display("FAIL spec_done got done=%b bv11=%b exp 1 1", log_mem[t+12].done, log_mem[t+11].block_valid);
        end
    endtask

    task automatic test_zero();
        cmd_t c;
        int t;
        c.wa = AW'($urandom); c.aa = AW'($urandom); c.len = LW'($urandom_range(1, 9)); c.zero = 1'b1;
        issue(c, t);
        repeat (4) @(negedge clk);
        for (int k = 0; k <= 3; k++) begin
            n_vec++;
            if (mask(log_mem[t+k]) !== mask(model(c, k, exp_skip))) begin
                n_err++;
                $display("FAIL zero_blk k=%0d got %h exp %h", k, mask(log_mem[t+k]), mask(model(c, k, exp_skip)));
            end
        end
        exp_skip = exp_skip + 16'd1;
        n_vec++;
        if (skip_cnt !== exp_skip) begin
            n_err++; $display("FAIL zero_skipcnt got %0d exp %0d", skip_cnt, exp_skip);
        end
    endtask

    task automatic test_random();
        cmd_t c;
        int t, d;
        for (int i = 0; i < 10; i++) begin
            c.wa = AW'($urandom); c.aa = AW'($urandom);
            c.len = (i == 3) ? '0 : LW'($urandom_range(1, 12));
            c.zero = (i != 3) && ($urandom_range(0, 3) == 0);
            d = blk_len(c);
            issue(c, t);
            repeat (d + 2) @(negedge clk);
            for (int k = 0; k <= d + 1; k++) begin
                n_vec++;
                if (mask(log_mem[t+k]) !== mask(model(c, k, exp_skip))) begin
                    n_err++;
                    $display("FAIL rand%0d k=%0d got %h exp %h", i, k, mask(log_mem[t+k]), mask(model(c, k, exp_skip)));
                end
            end
            if (c.zero || c.len == '0) exp_skip = exp_skip + 16'd1;
        end
    endtask

    task automatic test_back_to_back();
        cmd_t c1, c2;
        int t1, t2, d1, d2, lw;
        c1.wa = AW'($urandom); c1.aa = AW'($urandom); c1.len = LW'($urandom_range(1, 6)); c1.zero = 1'b0;
        c2.wa = AW'($urandom); c2.aa = AW'($urandom); c2.len = LW'($urandom_range(1, 6)); c2.zero = 1'b0;
        d1 = blk_len(c1); d2 = blk_len(c2);
        @(negedge clk);
        cmd_wgt_addr = c1.wa; cmd_act_addr = c1.aa; cmd_len = c1.len; cmd_zero = 1'b0;
        cmd_valid = 1'b1;
        t1 = cyc;
        @(negedge clk);
        cmd_wgt_addr = c2.wa; cmd_act_addr = c2.aa; cmd_len = c2.len;
        repeat (d1 - 1) @(negedge clk);
        t2 = t1 + d1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (d2 + 2) @(negedge clk);
        for (int k = 0; k <= d1; k++) begin
            n_vec++;
            if (mask(log_mem[t1+k]) !== mask(model(c1, k, exp_skip))) begin
                n_err++;
                $display("FAIL b2b_first k=%0d got %h exp %h", k, mask(log_mem[t1+k]), mask(model(c1, k, exp_skip)));
            end
        end
        lw = 0;
        for (int k = 1; k <= d2 + 1; k++) begin
            if (log_mem[t2+k].load_weight === 1'b1) lw++;
            n_vec++;
            if (mask(log_mem[t2+k]) !== mask(model(c2, k, exp_skip))) begin
                n_err++;
                $display("FAIL b2b_second k=%0d got %h exp %h", k, mask(log_mem[t2+k]), mask(model(c2, k, exp_skip)));
            end
        end
        n_vec++;
        if (lw !== NR) begin
            n_err++; $display("FAIL b2b_burst got %0d exp %0d", lw, NR);
        end
    endtask

    task automatic test_reset_mid();
        cmd_t c, c2;
        obs_t idle;
        int t, d;
        c.wa = AW'($urandom); c.aa = AW'($urandom); c.len = 9'd5; c.zero = 1'b0;
        idle = model(c, 0, 16'd0);
        issue(c, t);
        repeat (NR + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        for (int k = 0; k <= NR + 3; k++) begin
            n_vec++;
            if (mask(log_mem[t+k]) !== mask(model(c, k, exp_skip))) begin
                n_err++;
                $display("FAIL rstmid_pre k=%0d got %h exp %h", k, mask(log_mem[t+k]), mask(model(c, k, exp_skip)));
            end
        end
        for (int k = NR + 4; k <= NR + 9; k++) begin
            n_vec++;
            if (mask(log_mem[t+k]) !== idle) begin
                n_err++; $display("FAIL rstmid_idle k=%0d got %h exp %h", k, mask(log_mem[t+k]), idle);
            end
        end
        exp_skip = '0;
        c2.wa = AW'($urandom); c2.aa = AW'($urandom); c2.len = LW'($urandom_range(1, 8)); c2.zero = 1'b0;
        d = blk_len(c2);
        issue(c2, t);
        repeat (d + 2) @(negedge clk);
        for (int k = 0; k <= d + 1; k++) begin
            n_vec++;
            if (mask(log_mem[t+k]) !== mask(model(c2, k, exp_skip))) begin
                n_err++;
                $display("FAIL rstmid_next k=%0d got %h exp %h", k, mask(log_mem[t+k]), mask(model(c2, k, exp_skip)));
            end
        end
    endtask

    task automatic test_addr_wrap();
        cmd_t c = '{wa: 10'd1022, aa: 10'd1023, len: 9'd3, zero: 1'b0};
        int t, d;
        logic [AW-1:0] exp_a [3] = '{10'd1023, 10'd0, 10'd1};
        d = blk_len(c);
        issue(c, t);
        repeat (d + 2) @(negedge clk);
        for (int k = 0; k <= d + 1; k++) begin
            n_vec++;
            if (mask(log_mem[t+k]) !== mask(model(c, k, exp_skip))) begin
                n_err++;
                $display("FAIL wrap_blk k=%0d got %h exp %h", k, mask(log_mem[t+k]), mask(model(c, k, exp_skip)));
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (log_mem[t+NR+1+i].act_rd_addr !== exp_a[i] || log_mem[t+NR+1+i].act_rd_en !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_addr i=%0d got %0d en=%b exp %0d", i, log_mem[t+NR+1+i].act_rd_addr, log_mem[t+NR+1+i].act_rd_en, exp_a[i]);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_wgt_addr = '0; cmd_act_addr = '0; cmd_len = '0; cmd_zero = 1'b0;
        for (int i = 0; i < (1<<AW); i++) begin
            wmem[i] = NC*DW'($urandom);
            amem[i] = NR*DW'($urandom);
        end
        test_reset();
        test_spec_block();
        test_zero();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_addr_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
